// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stall, branch/jump flush, mult/div freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall,
  input  logic        br_taken,
  input  logic        jump_id,
  input  logic        md_start,
  output logic        PC_Write,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Bubble,
  output logic        md_done,
  output logic [1:0]  state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MD_BUSY  = 2'b10,
    ILLEGAL  = 2'b11
  } state_e;

  localparam logic [5:0] MdLoad = 6'(MD_CYCLES - 2);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  assign state = state_q;

  // State and freeze down-counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy control outputs
  always_comb begin
    state_d       = RUN;
    cnt_d         = cnt_q;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    md_done       = 1'b0;
    if (!reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN, LU_STALL: begin
          if (br_taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (md_start) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            cnt_d         = MdLoad;
            state_d       = MD_BUSY;
          end else if (hz_stall && state_q == RUN) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            state_d     = LU_STALL;
          end else if (jump_id) begin
            IF_ID_Flush = 1'b1;
          end
        end
        MD_BUSY: begin
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
          if (cnt_q == 6'd0) begin
            md_done = 1'b1;
            state_d = RUN;
          end else begin
            cnt_d   = cnt_q - 6'd1;
            state_d = MD_BUSY;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  // Count frozen-PC cycles and IF/ID flush cycles outside reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PC_Write)   stall_q <= stall_q + 32'd1;
      if (IF_ID_Flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Randomized + directed bench for hazard_sequencer against a cycle model
// built from "remaining freeze cycles" and "load-use bubble just issued".
module tb_hazard_sequencer;

  localparam int MDC = 4;

  logic        clk = 1'b0;
  logic        reset, hz_stall, br_taken, jump_id, md_start;
  logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic        EX_MEM_Bubble, md_done;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  int          rem = 0;
  bit          lu = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  always #5 clk = ~clk;

  hazard_sequencer #(.MD_CYCLES(MDC)) dut (
    .clk(clk), .reset(reset),
    .hz_stall(hz_stall), .br_taken(br_taken),
    .jump_id(jump_id), .md_start(md_start),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Bubble(EX_MEM_Bubble), .md_done(md_done),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit b, input bit m,
                      input bit h, input bit j);
    bit ep, ew, ef, ee, eb, ed, lu_n;
    int rem_n;
    logic [1:0] es;
    @(negedge clk);
    reset = r; br_taken = b; md_start = m;
    hz_stall = h; jump_id = j;
    #1;
    es = (rem > 0) ? 2'b10 : (lu ? 2'b01 : 2'b00);
    chk("state", 32'(state), 32'(es));
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    ep = 1; ew = 1; ef = 0; ee = 0; eb = 0; ed = 0;
    rem_n = rem; lu_n = 0;
    if (!r) begin
      ep = 0; ew = 0; ef = 1; ee = 1; rem_n = 0;
    end else if (rem > 0) begin
      ep = 0; ew = 0; eb = 1;
      ed = (rem == 1);
      rem_n = rem - 1;
    end else if (b) begin
      ef = 1; ee = 1;
    end else if (m) begin
      ep = 0; ew = 0; eb = 1; rem_n = MDC - 1;
    end else if (h && !lu) begin
      ep = 0; ew = 0; ee = 1; lu_n = 1;
    end else if (j) begin
      ef = 1;
    end
    chk("PC_Write", 32'(PC_Write), 32'(ep));
    chk("IF_ID_Write", 32'(IF_ID_Write), 32'(ew));
    chk("IF_ID_Flush", 32'(IF_ID_Flush), 32'(ef));
    chk("ID_EX_Flush", 32'(ID_EX_Flush), 32'(ee));
    chk("EX_MEM_Bubble", 32'(EX_MEM_Bubble), 32'(eb));
    chk("md_done", 32'(md_done), 32'(ed));
`ifdef HAZARD_PERF_CNT_EN
    if (!r) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!ep) m_stall = m_stall + 32'd1;
      if (ef)  m_flush = m_flush + 32'd1;
    end
`endif
    rem = rem_n;
    lu  = lu_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 0; hz_stall = 0; br_taken = 0;
    jump_id = 0; md_start = 0;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 0);
    idle(2);
    // load-use: hz held two cycles
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    idle(2);
    // mult/div freeze
    step(1, 0, 1, 0, 0);
    idle(5);
    // branch wins over md_start and hz_stall
    step(1, 1, 1, 1, 0);
    idle(1);
    // reset aborts MD_BUSY in its second cycle
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(3);
    // jump alone, and events inside LU_STALL
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    idle(4);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    // inputs ignored while busy
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
    idle(1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 59) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 The block SHALL have parameter MD_CYCLES, default 32, giving the multi-cycle (mult/div) stall length in cycles; the legal range is 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port hz_stall, input, 1 bit: load-use hazard detected for the instruction in ID.
REQ-005 The block SHALL have port br_taken, input, 1 bit: branch resolved taken in EX.
REQ-006 The block SHALL have port jump_id, input, 1 bit: jump decoded in ID.
REQ-007 The block SHALL have port md_start, input, 1 bit: a multi-cycle op is in EX this cycle.
REQ-008 The block SHALL have ports PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush and EX_MEM_Bubble, each output, 1 bit: pipeline-register enables and flushes.
REQ-009 The block SHALL have port md_done, output, 1 bit: one-cycle pulse on the last multi-cycle stall cycle.
REQ-010 The block SHALL have port state, output, 2 bits: current FSM state.
REQ-011 The block SHALL have ports stall_cnt and flush_cnt, output, 32 bits each: performance counters.

Function
REQ-012 The FSM SHALL have states RUN=2'b00, LU_STALL=2'b01 and MD_BUSY=2'b10; 2'b11 is illegal and SHALL return to RUN on the next edge with RUN outputs.
REQ-013 Outputs SHALL be combinational from the registered state and the current inputs (Mealy); state and counters SHALL be registered.
REQ-014 In RUN with no input active, outputs SHALL be PC_Write=1, IF_ID_Write=1 and all flushes, bubble and md_done 0.
REQ-015 RUN priority SHALL be br_taken > md_start > hz_stall > jump_id.
REQ-016 In RUN, br_taken SHALL give PC_Write=1, IF_ID_Flush=1, ID_EX_Flush=1 and next state RUN; md_start, hz_stall and jump_id are ignored that cycle.
REQ-017 In RUN, md_start without br_taken SHALL give PC_Write=0, IF_ID_Write=0 and EX_MEM_Bubble=1, load the down-counter with MD_CYCLES-2, and set next state MD_BUSY.
REQ-018 In MD_BUSY, the block SHALL hold PC_Write=0, IF_ID_Write=0 and EX_MEM_Bubble=1, and decrement the counter each cycle.
REQ-019 In MD_BUSY with counter==0, md_done SHALL be 1 and next state RUN; total freeze = MD_CYCLES cycles including the md_start cycle.
REQ-020 In MD_BUSY, br_taken, hz_stall, jump_id and md_start SHALL be ignored.
REQ-021 In RUN, hz_stall without br_taken or md_start SHALL give PC_Write=0, IF_ID_Write=0 and ID_EX_Flush=1, with next state LU_STALL.
REQ-022 LU_STALL SHALL last exactly one cycle with RUN outputs and next state RUN; hz_stall is ignored in LU_STALL (no back-to-back bubble).
REQ-023 In LU_STALL, br_taken SHALL still apply as in REQ-016 and jump_id as in REQ-024; md_start SHALL apply as in REQ-017.
REQ-024 In RUN, jump_id alone SHALL give IF_ID_Flush=1 with PC_Write=1 and IF_ID_Write=1.
REQ-025 The multi-cycle counter SHALL be 6 bits wide and SHALL never underflow.

Reset
REQ-026 When reset=0 at a rising edge, the block SHALL set state=RUN, counter=0, stall_cnt=0 and flush_cnt=0; this SHALL abort an in-progress MD_BUSY with no md_done pulse.
REQ-027 While reset=0, outputs SHALL be PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Bubble=0 and md_done=0.

Configuration
REQ-028 With macro HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment in every cycle with PC_Write=0 and reset=1, and flush_cnt SHALL increment in every cycle with IF_ID_Flush=1 and reset=1.
REQ-029 Both counters SHALL wrap modulo 2^32.
REQ-030 Without HAZARD_PERF_CNT_EN, stall_cnt and flush_cnt SHALL be constant 0 and no counter flops SHALL be synthesized; ports remain present.

Verification
REQ-031 Reset, then reset=1 with all inputs 0 -> state=00, PC_Write=1, IF_ID_Write=1, all flushes 0, counters 0.
REQ-032 hz_stall=1 for 2 cycles -> cycle 1: PC_Write=0 and ID_EX_Flush=1; cycle 2: state=01 with RUN outputs; cycle 3: state=00; stall_cnt=1.
REQ-033 md_start pulse with MD_CYCLES=4 -> PC_Write=0 for exactly 4 cycles, md_done=1 only in the 4th cycle, then state=00; stall_cnt=4.
REQ-034 br_taken=1, md_start=1 and hz_stall=1 in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, next state=00; flush_cnt=1.
REQ-035 reset=0 asserted in the 2nd MD_BUSY cycle -> state=00 next edge, md_done never pulses, stall_cnt=0.
REQ-036 Without HAZARD_PERF_CNT_EN, repeat REQ-033 -> identical control outputs, stall_cnt=0 and flush_cnt=0 throughout.
